// File: rtl/scan_chain_master_if.sv
// rtl/scan_chain_master_if.sv - request/response handshake bundle for scan_chain_master
interface scan_chain_master_if #(
   parameter int WIDTH = 16
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_data;
   logic             req_exec;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;

   modport master (
      output req_valid, req_data, req_exec, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_data, req_exec, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/scan_chain_master.sv
// rtl/scan_chain_master.sv - shifts a host word into the instruction scan chain, captures the old
// contents, optionally forces the word onto Q for EXEC_CYCLES cycles, and returns the capture.
module scan_chain_master #(
   parameter int WIDTH       = 16,
   parameter int EXEC_CYCLES = 1,
   parameter int CNT_W       = 5
) (
   input  logic               clk,
   input  logic               RST,
   scan_chain_master_if.slave bus,
   output logic               scan_in_o,
   output logic               scan_en_o,
   input  logic               scan_out_i,
   output logic               q_sel_o,
   output logic [WIDTH-1:0]   q_inject_o,
   output logic               busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, EXEC, RESP} state_t;

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'((EXEC_CYCLES > 0) ? EXEC_CYCLES - 1 : 0);
   localparam logic             HAS_EXEC   = (EXEC_CYCLES > 0);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] cap_q;
   logic             exec_q;
   logic             req_ready_q;
   logic             rsp_valid_q;

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = cap_q;
   // shift_q drains to zero during SHIFT, so its MSB is 0 in every other state
   assign scan_in_o     = shift_q[WIDTH-1];

   always_ff @(posedge clk) begin
      if (RST) begin
         state       <= IDLE;
         cnt         <= '0;
         shift_q     <= '0;
         cap_q       <= '0;
         exec_q      <= 1'b0;
         q_inject_o  <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         scan_en_o   <= 1'b1;
         q_sel_o     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  shift_q     <= bus.req_data;
                  q_inject_o  <= bus.req_data;
                  exec_q      <= bus.req_exec;
                  cnt         <= '0;
                  state       <= SHIFT;
                  req_ready_q <= 1'b0;
                  busy        <= 1'b1;
                  scan_en_o   <= 1'b0;
               end
            end
            SHIFT: begin
               shift_q <= {shift_q[WIDTH-2:0], 1'b0};
               // chain shifts on this same edge, so scan_out_i is still the old MSB
               cap_q   <= {cap_q[WIDTH-2:0], scan_out_i};
               cnt     <= cnt + 1'b1;
               if (cnt == SHIFT_LAST) begin
                  cnt       <= '0;
                  scan_en_o <= 1'b1;
                  if (exec_q && HAS_EXEC) begin
                     state   <= EXEC;
                     q_sel_o <= 1'b1;
                  end else begin
                     state       <= RESP;
                     rsp_valid_q <= 1'b1;
                  end
               end
            end
            EXEC: begin
               cnt <= cnt + 1'b1;
               if (cnt == EXEC_LAST) begin
                  state       <= RESP;
                  q_sel_o     <= 1'b0;
                  rsp_valid_q <= 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state       <= IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_scan_chain_master.sv
// tb/tb_scan_chain_master.sv - bench for scan_chain_master: two DUTs (EXEC_CYCLES=1 and 0)
// each driving a behavioural 16-bit scan chain.
module tb_scan_chain_master;
   localparam int W     = 16;
   localparam int EXEC0 = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;

   logic [1:0]        rv, rex, rrdy, pre_en;
   logic [1:0][W-1:0] rdat;
   logic [1:0]        rr, vv, s_in, s_en, s_out, q_sel, bsy;
   logic [1:0][W-1:0] rd, q_inj, chain, exp_chain;
   logic [W-1:0]      pre_val;
   int                acc_cyc [2];

   scan_chain_master_if #(.WIDTH(W)) if0 ();
   scan_chain_master_if #(.WIDTH(W)) if1 ();

   assign if0.req_valid = rv[0];
   assign if0.req_data  = rdat[0];
   assign if0.req_exec  = rex[0];
   assign if0.rsp_ready = rrdy[0];
   assign if1.req_valid = rv[1];
   assign if1.req_data  = rdat[1];
   assign if1.req_exec  = rex[1];
   assign if1.rsp_ready = rrdy[1];
   assign rr    = {if1.req_ready, if0.req_ready};
   assign vv    = {if1.rsp_valid, if0.rsp_valid};
   assign rd    = {if1.rsp_data, if0.rsp_data};
   assign s_out = {chain[1][W-1], chain[0][W-1]};

   scan_chain_master #(.WIDTH(W), .EXEC_CYCLES(EXEC0), .CNT_W(5)) dut0 (
      .clk(clk), .RST(rst), .bus(if0),
      .scan_in_o(s_in[0]), .scan_en_o(s_en[0]), .scan_out_i(s_out[0]),
      .q_sel_o(q_sel[0]), .q_inject_o(q_inj[0]), .busy(bsy[0])
   );

   scan_chain_master #(.WIDTH(W), .EXEC_CYCLES(0), .CNT_W(5)) dut1 (
      .clk(clk), .RST(rst), .bus(if1),
      .scan_in_o(s_in[1]), .scan_en_o(s_en[1]), .scan_out_i(s_out[1]),
      .q_sel_o(q_sel[1]), .q_inject_o(q_inj[1]), .busy(bsy[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // controller chain: shift when scan_en=0, else parallel load from the Q mux (holds by default)
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (s_en[d] == 1'b0)       chain[d] <= {chain[d][W-2:0], s_in[d]};
         else if (q_sel[d] == 1'b1) chain[d] <= q_inj[d];
         else if (pre_en[d])        chain[d] <= pre_val;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input int d, input logic after_rst);
      chk("idle_req_ready", 32'(rr[d]), 32'd1);
      chk("idle_rsp_valid", 32'(vv[d]), 32'd0);
      chk("idle_scan_en",   32'(s_en[d]), 32'd1);
      chk("idle_scan_in",   32'(s_in[d]), 32'd0);
      chk("idle_q_sel",     32'(q_sel[d]), 32'd0);
      chk("idle_busy",      32'(bsy[d]), 32'd0);
      if (after_rst) begin
         chk("rst_rsp_data",  32'(rd[d]), 32'd0);
         chk("rst_q_inject",  32'(q_inj[d]), 32'd0);
      end
   endtask

   task automatic txn(input int d, input logic [W-1:0] w, input logic ex, input int hold,
                      input int rst_at);
      int           k;
      int           nq;
      int           lat_exp;
      int           n_exec;
      int           seen;
      logic [W-1:0] exp_rsp;
      k = 0;
      while (rr[d] !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("req_ready_wait", 32'(rr[d]), 32'd1);
      exp_rsp = exp_chain[d];
      n_exec  = (ex && d == 0) ? EXEC0 : 0;
      lat_exp = W + 1 + n_exec;
      acc_cyc[d] = cyc;
      rv[d] = 1'b1;
      rdat[d] = w;
      rex[d] = ex;
      @(negedge clk);
      rv[d] = 1'b0;
      rdat[d] = W'($urandom);
      rex[d] = 1'($urandom_range(0, 1));
      nq = 0;
      for (k = 1; k <= lat_exp + 4 && vv[d] !== 1'b1; k++) begin
         if (k == rst_at) begin
            rv[d] = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk_idle(d, 1'b1);
            exp_chain[d] = (exp_chain[d] << k) | (w >> (W - k));
            seen = 0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (vv[d] !== 1'b0) seen++;
            end
            chk("no_partial_rsp", 32'(seen), 32'd0);
            return;
         end
         chk("busy_high", 32'(bsy[d]), 32'd1);
         chk("req_ready_low", 32'(rr[d]), 32'd0);
         if (k <= W) begin
            chk("scan_en_shift", 32'(s_en[d]), 32'd0);
            chk("scan_in_bit", 32'(s_in[d]), 32'(w[W-k]));
         end else begin
            chk("scan_en_exec", 32'(s_en[d]), 32'd1);
         end
         if (q_sel[d] === 1'b1) begin
            nq++;
            chk("q_inject", 32'(q_inj[d]), 32'(w));
         end
         rv[d] = (k < W) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
      end
      chk("latency", 32'(k), 32'(lat_exp));
      chk("q_sel_cycles", 32'(nq), 32'(n_exec));
      chk("rsp_data", 32'(rd[d]), 32'(exp_rsp));
      chk("chain_loaded", 32'(chain[d]), 32'(w));
      for (int h = 0; h < hold; h++) begin
         rrdy[d] = 1'b0;
         rv[d] = (h == 1);
         @(negedge clk);
         chk("rsp_valid_hold", 32'(vv[d]), 32'd1);
         chk("rsp_data_hold", 32'(rd[d]), 32'(exp_rsp));
         chk("req_ready_resp", 32'(rr[d]), 32'd0);
      end
      rv[d] = 1'b0;
      rrdy[d] = 1'b1;
      @(negedge clk);
      rrdy[d] = 1'b0;
      chk_idle(d, 1'b0);
      exp_chain[d] = w;
   endtask

   initial begin
      int a;
      int ra;
      rv = '0;
      rex = '0;
      rrdy = '0;
      pre_en = '0;
      pre_val = '0;
      rdat = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_idle(0, 1'b1);
      chk_idle(1, 1'b1);
      rst = 1'b0;

      pre_val = 16'h1234;
      pre_en = 2'b11;
      @(negedge clk);
      pre_en = '0;
      exp_chain[0] = 16'h1234;
      exp_chain[1] = 16'h1234;
      @(negedge clk);

      txn(0, 16'h5A3C, 1'b0, 0, -1);
      txn(0, 16'h5103, 1'b1, 0, -1);
      txn(0, W'($urandom), 1'b0, 5, -1);
      txn(0, W'($urandom), 1'b0, 0, 8);
      txn(0, W'($urandom), 1'b1, 0, -1);
      txn(0, 16'hFFFF, 1'b0, 0, -1);
      a = acc_cyc[0];
      txn(0, 16'h0000, 1'b0, 0, -1);
      chk("accept_gap", 32'((acc_cyc[0] - a) >= W + 2), 32'd1);

      txn(1, W'($urandom), 1'b1, 0, -1);
      txn(1, W'($urandom), 1'b1, 2, -1);

      for (int t = 0; t < 24; t++) begin
         ra = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W)) : -1;
         txn(0, W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), ra);
      end
      for (int t = 0; t < 4; t++) begin
         txn(1, W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/scan_chain_master.md
Name: scan_chain_master

Overview:
- Serial driver for the controller's instruction scan chain.
- The chain is 16 bits and MSB-out. Each cycle it either shifts in `scan_in` with `scan_en`=0, or parallel-loads Q with `scan_en`=1. `scan_out` is the chain MSB.
- The block accepts a parallel word from the test/host port and shifts it into the chain MSB-first. It captures the chain's previous contents from `scan_out` as it shifts.
- Optionally, it then forces the injected word onto the controller's Q input for a fixed number of cycles so the instruction executes. It returns the captured word on a response handshake.

Parameters:
- WIDTH, 16, scan chain length and data word width.
- EXEC_CYCLES, 1, number of cycles the injected word is held on Q when exec is requested; 0 disables the EXEC state.
- CNT_W, 5, counter width; must satisfy 2^CNT_W > max(WIDTH, EXEC_CYCLES).

Ports:
- clk  input  1  clock.
- RST  input  1  reset, synchronous, active-high.
- req_valid  input  1  request word valid.
- req_ready  output  1  block can accept a request.
- req_data  input  WIDTH  word to shift into the chain.
- req_exec  input  1  after shifting, hold the word on Q for EXEC_CYCLES cycles.
- rsp_valid  output  1  captured word valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WIDTH  previous chain contents, captured MSB-first.
- scan_in_o  output  1  drives controller `scan_in`.
- scan_en_o  output  1  drives controller `scan_en` (0 = shift, 1 = parallel load).
- scan_out_i  input  1  from controller `scan_out`.
- q_sel_o  output  1  top-level Q mux select (1 = take q_inject_o instead of fetch Q).
- q_inject_o  output  WIDTH  word forced onto Q during EXEC.
- busy  output  1  high in any state other than IDLE; used to gate fetch/PC.

Behaviour:
- Interface decision: one clock `clk`; reset `RST` is synchronous and active-high.
- States and encoding: IDLE, SHIFT, EXEC, RESP. State is registered; all outputs are decoded from registered state and registers.
- Reset (RST=1 at posedge), including mid-operation: state returns to IDLE and the counter is cleared. Resulting output values:
  - req_ready=1, rsp_valid=0, rsp_data=0.
  - scan_in_o=0, scan_en_o=1, q_sel_o=0, q_inject_o=0, busy=0.
  - No partial response is produced.
- IDLE:
  - Outputs: req_ready=1, scan_en_o=1, q_sel_o=0, scan_in_o=0.
  - On req_valid&&req_ready: latch req_data into the shift register and q_inject_o, latch req_exec, clear the counter, go to SHIFT.
- SHIFT (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Outputs: scan_en_o=0, scan_in_o = shift-register MSB.
  - Each posedge: shift register shifts left; the capture register shifts left taking scan_out_i into its LSB; counter increments.
  - Sampling at the same edge the chain shifts means the capture reads the old chain MSB. After WIDTH edges, capture = previous chain word and chain = req_data.
  - At count WIDTH-1, next state is EXEC if latched exec=1 and EXEC_CYCLES>0, else RESP.
- EXEC (EXEC_CYCLES cycles):
  - Outputs: scan_en_o=1, q_sel_o=1, q_inject_o = latched word, so the chain reloads the same word each cycle.
  - After the last cycle, go to RESP.
- RESP:
  - Outputs: rsp_valid=1, rsp_data = capture register, held stable while rsp_ready=0.
  - scan_en_o=1, q_sel_o=0.
  - On rsp_ready, go to IDLE (rsp_valid drops the next cycle).
- req_ready=0 in SHIFT/EXEC/RESP; req_valid there is ignored and not queued.
- Latency, accept to rsp_valid: WIDTH+1 cycles without exec; WIDTH+EXEC_CYCLES+1 with exec.
- Back-to-back throughput: next accept no earlier than the cycle after the response handshake.
- q_inject_o retains the last word after EXEC; only q_sel_o gates its use.

Test Plan:
- Preload chain 16'h1234 via Q with scan_en_o=1, then request 16'h5A3C with exec=0 → 16 cycles of scan_en_o=0; scan_in_o sequence 0,1,0,1,1,0,1,0,0,0,1,1,1,1,0,0; rsp_valid at cycle 17 with rsp_data=16'h1234; chain holds 16'h5A3C.
- Request 16'h5103 (ADDI) with exec=1, EXEC_CYCLES=1 → after shift, one cycle with q_sel_o=1 and q_inject_o=16'h5103; controller performs the write; rsp_valid at cycle 18.
- rsp_ready held 0 for 5 cycles in RESP → rsp_valid and rsp_data stable; req_ready=0; a req_valid pulse is ignored.
- Assert RST at SHIFT count 7 → next cycle IDLE, scan_en_o=1, busy=0, rsp_valid never asserts; a new request then completes normally.
- Two consecutive requests, 16'hFFFF then 16'h0000 → second rsp_data=16'hFFFF (readback of first); first accept-to-second-accept gap ≥ WIDTH+2 cycles.
- EXEC_CYCLES=0 with req_exec=1 → EXEC is skipped; q_sel_o never asserts; latency WIDTH+1.
